// File: rtl/rr_mux_arbiter_pkg.sv
// rr_mux_arbiter_pkg: shared constants and one-hot decode for the round-robin mux arbiter
package rr_mux_arbiter_pkg;
    localparam int N_REQ = 4;
    localparam int ID_W = 2;
    function automatic logic [ID_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        onehot_to_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) onehot_to_idx |= ID_W'(i);
    endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester-side and consumer-side handshake bundle
interface rr_mux_arbiter_if #(parameter int W = 4);
    import rr_mux_arbiter_pkg::*;
    logic [N_REQ-1:0] in_valid;
    logic [N_REQ-1:0] in_ready;
    logic [W-1:0] in_data [0:N_REQ-1];
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_data;
    logic [ID_W-1:0] out_id;
    modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_id);
    modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_id);
endinterface

// File: rtl/rr_mux_arbiter_rr_pick_4.sv
// rr_pick_4: first requester at or after ptr, wrapping modulo 4
module rr_pick_4
    import rr_mux_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             gnt_valid,
    output logic [ID_W-1:0]  gnt_idx
);
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first;
    always_comb begin
        // rotate so ptr lands at bit 0, isolate lowest set bit, then rotate the index back
        rot = N_REQ'({req, req} >> ptr);
        first = rot & (~rot + 1'b1);
        gnt_valid = |req;
        gnt_idx = ptr + onehot_to_idx(first);
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: 4-way round-robin arbiter feeding a single registered output slot
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int W = 4
) (
    input logic clk,
    input logic rst,
    rr_mux_arbiter_if.slave bus
);
    logic gnt_valid;
    logic take;
    logic [ID_W-1:0] gnt_idx;
    logic [ID_W-1:0] ptr;
    logic [W-1:0] sel_data;
    rr_pick_4 u_pick (
        .req(bus.in_valid),
        .ptr(ptr),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );
    always_comb begin
        sel_data = bus.in_data[gnt_idx];
        take = gnt_valid && !rst && (!bus.out_valid || bus.out_ready);
        bus.in_ready = take ? N_REQ'(1) << gnt_idx : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data <= '0;
            bus.out_id <= '0;
            ptr <= '0;
        end else if (take) begin
            bus.out_valid <= 1'b1;
            bus.out_data <= sel_data;
            bus.out_id <= gnt_idx;
            ptr <= gnt_idx + 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
